mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single external memory port between instruction fetch and the execute-stage data request (memctrl vld/wr/sign/size/addr/wdata).
- Sequences each access as a registered bus transaction.
- Generates byte enables.
- Aligns, rotates and extends load data.
- Stalls the pipeline until the data transfer completes.
- Data has priority over fetch; a starvation counter guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, consecutive data grants while fetch is pending before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 16, bus cycles without ack before abort (used only with MEM_BUS_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_if_req  in  1  fetch request, held until o_if_rvld
i_if_addr  in  32  fetch address (word aligned, [1:0] ignored)
o_if_rvld  out  1  fetch data valid (1-cycle pulse)
o_if_rdata  out  32  fetch word
i_memctrl_vld  in  1  data request, held while o_mem_stall=1
i_memctrl_wr  in  1  1=store, 0=load
i_memctrl_sign  in  1  sign-extend load
i_memctrl_size  in  2  00 byte, 01 half, 10/11 word
i_memctrl_addr  in  32  data address
i_memctrl_wdata  in  32  store data (LSB-aligned)
o_mem_stall  out  1  pipeline stall
o_mem_rvld  out  1  load data valid (1-cycle pulse)
o_mem_rdata  out  32  extended/rotated load data
o_bus_req  out  1  bus request, registered
o_bus_wr  out  1  bus write, registered
o_bus_addr  out  32  word address ([1:0]=0), registered
o_bus_be  out  4  byte enables, registered
o_bus_wdata  out  32  lane-replicated write data, registered
i_bus_ack  in  1  transfer complete
i_bus_rdata  in  32  read data, valid with ack
o_bus_err  out  1  timeout pulse (0 without MEM_BUS_TIMEOUT_EN)

Behaviour:
- Reset: state=IDLE, starve_cnt=0, all registered bus outputs 0. Async assertion mid-transfer drops o_bus_req immediately; the in-flight access is lost and no rvld is issued.
- States: IDLE, IF_XFER, D_XFER.
- IDLE arbitration, evaluated each cycle, grant registered on the clock edge:
  - data only -> D_XFER
  - fetch only -> IF_XFER
  - both pending, starve_cnt<STARVE_LIMIT -> D_XFER, starve_cnt+1
  - both pending, starve_cnt==STARVE_LIMIT -> IF_XFER
  - any fetch grant clears starve_cnt
- On entering XFER, bus outputs load from the granted requester. o_bus_req=1 throughout XFER; addr/wr/be/wdata stay stable until ack.
- i_bus_ack in XFER:
  - rvld pulses for the owner in the same cycle; rdata is combinational from i_bus_rdata.
  - o_bus_req clears and state returns to IDLE on the next edge.
  - Minimum access time is 2 cycles (grant cycle + ack cycle). No chaining from the ack cycle, so a still-held request is never re-granted.
- o_mem_stall = i_memctrl_vld & ~(state==D_XFER & i_bus_ack). It therefore covers both waiting for the grant and waiting for ack.
- Byte enables (a=addr[1:0]):
  - byte: 0001<<a
  - half: 0011<<(2*a[1])
  - word: 1111
  - fetch: 1111
- Write data: byte value replicated into all 4 lanes; half value into both halves; word passed unchanged.
- Load data:
  - byte: lane a, zero- or sign-extended from bit 7.
  - half: halfword a[1], zero- or sign-extended from bit 15. a[0] is ignored.
  - word: rdata rotated right by 8*a (ARMv4 unaligned LDR).
- Stores also pulse o_mem_rvld on ack; rdata is don't-care for stores.
- Data request dropped before grant: no transaction. Dropping after grant is illegal; the transaction completes regardless.

Optional Feature:
MEM_BUS_TIMEOUT_EN
- Defined:
  - A counter clears on XFER entry and increments each XFER cycle without ack.
  - At TIMEOUT_CYCLES: o_bus_err pulses 1 cycle, the owner's rvld pulses with rdata=0, o_bus_req drops, state -> IDLE.
  - Ack in the same cycle as the limit wins (no error).
- Undefined: XFER waits indefinitely for ack; o_bus_err is tied 0 and no counter logic exists.

Test Plan:
1. Fetch only: i_if_req=1, addr=0x100; ack in the 2nd XFER cycle, rdata=0xE3A00001 -> o_bus_be=1111, o_bus_addr=0x100, o_if_rvld pulses once with 0xE3A00001, state returns to IDLE.
2. LDRSB addr=0x203, bus rdata=0x80FF7F01 -> be=1000, o_mem_rdata=0xFFFFFF80; same with sign=0 -> 0x00000080. Stall is held until ack.
3. Store half addr=0x402, wdata=0x0000BEEF -> be=1100, o_bus_wdata=0xBEEFBEEF, o_bus_wr=1; unaligned LDR addr=0x401, rdata=0x44332211 -> 0x11443322.
4. Fetch and data both requesting continuously, STARVE_LIMIT=4, ack every XFER cycle -> grant order D,D,D,D,F,D,D,D,D,F.
5. Assert i_rst_n=0 mid D_XFER -> o_bus_req=0 with no clock edge, no rvld; after release, state is IDLE and the held request is re-granted.
6. MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives -> o_bus_err and o_mem_rvld pulse together with o_mem_rdata=0, o_mem_stall falls, o_bus_req=0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access. Each access takes at least 2 cycles (grant, then ack).
// Stalls the pipeline until ack. Optional bus timeout: MEM_BUS_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_rvld,
  output logic [31:0] o_if_rdata,
  input  logic        i_memctrl_vld,
  input  logic        i_memctrl_wr,
  input  logic        i_memctrl_sign,
  input  logic [1:0]  i_memctrl_size,
  input  logic [31:0] i_memctrl_addr,
  input  logic [31:0] i_memctrl_wdata,
  output logic        o_mem_stall,
  output logic        o_mem_rvld,
  output logic [31:0] o_mem_rdata,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("STARVE_LIMIT must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, IF_XFER, D_XFER} state_t;

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        d_sign;
  logic [1:0]  d_size;
  logic [1:0]  d_lane;
  logic        tmo;
  logic        done;
  logic        grant_d;
  logic        grant_f;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] rd;
  logic [31:0] rot;
  logic [15:0] half;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TMO_MAX = TCW'(TIMEOUT_CYCLES);
  logic [TCW-1:0] tmo_cnt;

  // Counts XFER cycles that ended without ack; held at zero while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!i_bus_ack) begin
      tmo_cnt <= tmo_cnt + TCW'(1);
    end
  end

  assign tmo = (state != IDLE) & ~i_bus_ack & (tmo_cnt == TMO_MAX);
`else
  assign tmo = 1'b0;
`endif

  assign done      = (state != IDLE) & (i_bus_ack | tmo);
  assign o_bus_err = tmo;

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  assign grant_d = i_memctrl_vld & (~i_if_req | (starve_cnt < STARVE_MAX));
  assign grant_f = i_if_req & ~grant_d;

  always_comb begin
    d_be    = 4'b1111;
    d_wdata = i_memctrl_wdata;
    case (i_memctrl_size)
      2'b00: begin
        d_be    = 4'b0001 << i_memctrl_addr[1:0];
        d_wdata = {4{i_memctrl_wdata[7:0]}};
      end
      2'b01: begin
        d_be    = 4'b0011 << {i_memctrl_addr[1], 1'b0};
        d_wdata = {2{i_memctrl_wdata[15:0]}};
      end
      default: begin
        d_be    = 4'b1111;
        d_wdata = i_memctrl_wdata;
      end
    endcase
  end

  assign rd = tmo ? 32'h0 : i_bus_rdata;

  always_comb begin
    case (d_lane)
      2'd1:    rot = {rd[7:0],  rd[31:8]};
      2'd2:    rot = {rd[15:0], rd[31:16]};
      2'd3:    rot = {rd[23:0], rd[31:24]};
      default: rot = rd;
    endcase
  end

  assign half = d_lane[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    case (d_size)
      2'b00:   o_mem_rdata = {{24{d_sign & rot[7]}}, rot[7:0]};
      2'b01:   o_mem_rdata = {{16{d_sign & half[15]}}, half};
      default: o_mem_rdata = rot;
    endcase
  end

  assign o_if_rdata  = rd;
  assign o_if_rvld   = (state == IF_XFER) & done;
  assign o_mem_rvld  = (state == D_XFER) & done;
  assign o_mem_stall = i_memctrl_vld & ~((state == D_XFER) & done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      o_bus_req   <= 1'b0;
      o_bus_wr    <= 1'b0;
      o_bus_addr  <= 32'h0;
      o_bus_be    <= 4'h0;
      o_bus_wdata <= 32'h0;
      d_sign      <= 1'b0;
      d_size      <= 2'b00;
      d_lane      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= D_XFER;
            o_bus_req   <= 1'b1;
            o_bus_wr    <= i_memctrl_wr;
            o_bus_addr  <= i_memctrl_addr & WORD_MASK;
            o_bus_be    <= d_be;
            o_bus_wdata <= d_wdata;
            d_sign      <= i_memctrl_sign;
            d_size      <= i_memctrl_size;
            d_lane      <= i_memctrl_addr[1:0];
            if (i_if_req) starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_f) begin
            state       <= IF_XFER;
            o_bus_req   <= 1'b1;
            o_bus_wr    <= 1'b0;
            o_bus_addr  <= i_if_addr & WORD_MASK;
            o_bus_be    <= 4'b1111;
            o_bus_wdata <= 32'h0;
            starve_cnt  <= 4'd0;
          end
        end
        default: begin
          // No chaining: always pass through IDLE before the next grant.
          if (i_bus_ack | tmo) begin
            state     <= IDLE;
            o_bus_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand sequences for
// starvation, async reset mid-transfer and bus timeout.
module tb_mem_port_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_rvld;
  logic [31:0] o_if_rdata;
  logic        i_memctrl_vld;
  logic        i_memctrl_wr;
  logic        i_memctrl_sign;
  logic [1:0]  i_memctrl_size;
  logic [31:0] i_memctrl_addr;
  logic [31:0] i_memctrl_wdata;
  logic        o_mem_stall;
  logic        o_mem_rvld;
  logic [31:0] o_mem_rdata;
  logic        o_bus_req;
  logic        o_bus_wr;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        o_bus_err;

  mem_port_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rvld(o_if_rvld), .o_if_rdata(o_if_rdata),
    .i_memctrl_vld(i_memctrl_vld), .i_memctrl_wr(i_memctrl_wr),
    .i_memctrl_sign(i_memctrl_sign), .i_memctrl_size(i_memctrl_size),
    .i_memctrl_addr(i_memctrl_addr), .i_memctrl_wdata(i_memctrl_wdata),
    .o_mem_stall(o_mem_stall), .o_mem_rvld(o_mem_rvld), .o_mem_rdata(o_mem_rdata),
    .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr),
    .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_bus_err(o_bus_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        fetch;
    logic        wr;
    logic        sign;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] res;
  } vec_t;

  vec_t vt [12];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drop_reqs();
    i_if_req      = 1'b0;
    i_memctrl_vld = 1'b0;
    i_bus_ack     = 1'b0;
  endtask

  // Waits for o_bus_req within a cycle budget; returns at edge+1.
  task automatic wait_grant(input string nm);
    bit got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge i_clk); #1;
      got = o_bus_req;
    end
    chk(nm, 32'(got), 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.fetch) begin
      i_if_req  = 1'b1;
      i_if_addr = v.addr;
    end else begin
      i_memctrl_vld   = 1'b1;
      i_memctrl_wr    = v.wr;
      i_memctrl_sign  = v.sign;
      i_memctrl_size  = v.size;
      i_memctrl_addr  = v.addr;
      i_memctrl_wdata = v.wdata;
    end
    #1;
    if (!v.fetch) chk($sformatf("v%0d_stall_pre", idx), 32'(o_mem_stall), 32'h1);
    wait_grant($sformatf("v%0d_grant", idx));
    chk($sformatf("v%0d_be", idx), 32'(o_bus_be), 32'(v.be));
    chk($sformatf("v%0d_addr", idx), o_bus_addr, v.baddr);
    chk($sformatf("v%0d_wr", idx), 32'(o_bus_wr), 32'(v.wr));
    if (v.wr) chk($sformatf("v%0d_wdata", idx), o_bus_wdata, v.bwdata);
    for (int d = 0; d < v.dly; d++) begin
      chk($sformatf("v%0d_rvld_early", idx), 32'(o_if_rvld | o_mem_rvld), 32'h0);
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_req_held", idx), 32'(o_bus_req), 32'h1);
      if (!v.fetch) chk($sformatf("v%0d_stall_held", idx), 32'(o_mem_stall), 32'h1);
    end
    i_bus_ack   = 1'b1;
    i_bus_rdata = v.rdata;
    #1;
    if (v.fetch) begin
      chk($sformatf("v%0d_if_rvld", idx), 32'(o_if_rvld), 32'h1);
      chk($sformatf("v%0d_if_rdata", idx), o_if_rdata, v.res);
      chk($sformatf("v%0d_mem_rvld", idx), 32'(o_mem_rvld), 32'h0);
    end else begin
      chk($sformatf("v%0d_mem_rvld", idx), 32'(o_mem_rvld), 32'h1);
      chk($sformatf("v%0d_stall_ack", idx), 32'(o_mem_stall), 32'h0);
      if (!v.wr) chk($sformatf("v%0d_rdata", idx), o_mem_rdata, v.res);
    end
    @(posedge i_clk); #1;
    drop_reqs();
    #1;
    chk($sformatf("v%0d_req_clear", idx), 32'(o_bus_req), 32'h0);
    chk($sformatf("v%0d_rvld_after", idx), 32'(o_if_rvld | o_mem_rvld), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_f;
    int         grants;
    int         cyc;
    int         err_seen;

    //            fetch wr    sign  size   addr          wdata         rdata         dly be     baddr         bwdata        res
    vt[0]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0,        32'hE3A00001, 1, 4'hF, 32'h100, 32'h0,        32'hE3A00001};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h203, 32'h0,        32'h80FF7F01, 2, 4'h8, 32'h200, 32'h0,        32'hFFFFFF80};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h203, 32'h0,        32'h80FF7F01, 0, 4'h8, 32'h200, 32'h0,        32'h00000080};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h402, 32'h0000BEEF, 32'h0,        1, 4'hC, 32'h400, 32'hBEEFBEEF, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 2'b10, 32'h401, 32'h0,        32'h44332211, 0, 4'hF, 32'h400, 32'h0,        32'h11443322};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h302, 32'h0,        32'h80017FFF, 1, 4'hC, 32'h300, 32'h0,        32'hFFFF8001};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h301, 32'h0,        32'h80017FFF, 0, 4'h3, 32'h300, 32'h0,        32'h00007FFF};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h501, 32'h123456AB, 32'h0,        0, 4'h2, 32'h500, 32'hABABABAB, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h600, 32'hDEADBEEF, 32'h0,        2, 4'hF, 32'h600, 32'hDEADBEEF, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h102, 32'h0,        32'h11AA2233, 0, 4'h4, 32'h100, 32'h0,        32'h000000AA};
    vt[10] = '{1'b0, 1'b0, 1'b0, 2'b11, 32'h403, 32'h0,        32'h44332211, 1, 4'hF, 32'h400, 32'h0,        32'h33221144};
    vt[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h107, 32'h0,        32'h12345678, 0, 4'hF, 32'h104, 32'h0,        32'h12345678};

    i_rst_n = 1'b0;
    i_if_req = 1'b0; i_if_addr = 32'h0;
    i_memctrl_vld = 1'b0; i_memctrl_wr = 1'b0; i_memctrl_sign = 1'b0;
    i_memctrl_size = 2'b00; i_memctrl_addr = 32'h0; i_memctrl_wdata = 32'h0;
    i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    #1;
    chk("rst_req", 32'(o_bus_req), 32'h0);
    chk("rst_wr", 32'(o_bus_wr), 32'h0);
    chk("rst_addr", o_bus_addr, 32'h0);
    chk("rst_be", 32'(o_bus_be), 32'h0);
    chk("rst_wdata", o_bus_wdata, 32'h0);
    chk("rst_rvld", 32'(o_if_rvld | o_mem_rvld), 32'h0);
    chk("rst_err", 32'(o_bus_err), 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Both requesters held: expect D,D,D,D,F,D,D,D,D,F (bit k set = fetch grant).
    i_rst_n = 1'b0; #1; i_rst_n = 1'b1;
    exp_f = 10'b10000_10000;
    i_if_req = 1'b1; i_if_addr = 32'h800;
    i_memctrl_vld = 1'b1; i_memctrl_wr = 1'b0; i_memctrl_size = 2'b10;
    i_memctrl_addr = 32'h900;
    grants = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      @(posedge i_clk); #1;
      i_bus_ack = 1'b0;
      if (o_bus_req) begin
        chk($sformatf("starve_g%0d", grants), o_bus_addr, exp_f[grants] ? 32'h800 : 32'h900);
        grants++;
        i_bus_ack = 1'b1;
      end
    end
    chk("starve_grants", 32'(grants), 32'd10);
    @(posedge i_clk); #1;
    drop_reqs();
    @(posedge i_clk); #1;

    // Async reset in the middle of a data transfer.
    i_memctrl_vld = 1'b1; i_memctrl_wr = 1'b0; i_memctrl_size = 2'b10;
    i_memctrl_addr = 32'hA00;
    wait_grant("rst_mid_grant");
    #1;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h55AA55AA;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(o_bus_req), 32'h0);
    chk("rst_mid_rvld", 32'(o_mem_rvld), 32'h0);
    chk("rst_mid_stall", 32'(o_mem_stall), 32'h1);
    i_bus_ack = 1'b0;
    #2;
    i_rst_n = 1'b1;
    wait_grant("rst_regrant");
    chk("rst_regrant_addr", o_bus_addr, 32'hA00);
    i_bus_ack = 1'b1;
    #1;
    chk("rst_regrant_rvld", 32'(o_mem_rvld), 32'h1);
    chk("rst_regrant_rdata", o_mem_rdata, 32'h55AA55AA);
    @(posedge i_clk); #1;
    drop_reqs();
    @(posedge i_clk); #1;

    // No ack ever arrives.
    i_memctrl_vld = 1'b1; i_memctrl_addr = 32'hC00; i_bus_rdata = 32'hFFFFFFFF;
    wait_grant("tmo_grant");
    chk("tmo_err_first", 32'(o_bus_err), 32'h0);
`ifdef MEM_BUS_TIMEOUT_EN
    cyc = 0;
    while (!o_bus_err && cyc < 40) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    chk("tmo_cycles", 32'(cyc), 32'd16);
    chk("tmo_err", 32'(o_bus_err), 32'h1);
    chk("tmo_rvld", 32'(o_mem_rvld), 32'h1);
    chk("tmo_rdata", o_mem_rdata, 32'h0);
    chk("tmo_stall", 32'(o_mem_stall), 32'h0);
    @(posedge i_clk); #1;
    chk("tmo_req_drop", 32'(o_bus_req), 32'h0);
    chk("tmo_err_pulse", 32'(o_bus_err), 32'h0);
    drop_reqs();
    err_seen = 0;
`else
    err_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk); #1;
      if (o_bus_err) err_seen++;
    end
    chk("notmo_err", 32'(err_seen), 32'h0);
    chk("notmo_req", 32'(o_bus_req), 32'h1);
    chk("notmo_stall", 32'(o_mem_stall), 32'h1);
    i_bus_ack = 1'b1;
    #1;
    chk("notmo_rvld", 32'(o_mem_rvld), 32'h1);
    @(posedge i_clk); #1;
    drop_reqs();
`endif
    @(posedge i_clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
